// File: rtl/aurras_pkg.sv
// Shared types and widths for the impulse recorder: capture states, sample and
// magnitude widths, and the sample magnitude helper.
package aurras_pkg;

  localparam int SAMPLE_W = 16;
  localparam int MAG_W    = 17;
  localparam int ADDR_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RECORDING,
    ST_DONE
  } rec_state_t;

  // Widened by one bit so that -32768 maps to 32768 instead of wrapping.
  function automatic logic [MAG_W-1:0] sample_magnitude(input logic signed [SAMPLE_W-1:0] s);
    logic signed [MAG_W-1:0] ext;
    ext = MAG_W'(s);
    return ext[MAG_W-1] ? MAG_W'(-ext) : MAG_W'(ext);
  endfunction

endpackage

// File: rtl/onset_detector.sv
// Combinational magnitude-versus-threshold compare; used for onset detection
// and, with a moving threshold, for peak tracking.
module onset_detector
  import aurras_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic [MAG_W-1:0]           threshold_i,
  output logic                       hit_o
);

  assign hit_o = sample_magnitude(sample_i) >= threshold_i;

endmodule

// File: rtl/impulse_recorder.sv
// Arms on start_in, waits for an onset sample, then streams IMPULSE_LENGTH samples
// to impulse memory. Optional peak tracking via macro IMPULSE_PEAK_TRACK_EN.
module impulse_recorder
  import aurras_pkg::*;
#(
  parameter int IMPULSE_LENGTH  = 48000,
  parameter int ONSET_THRESHOLD = 2000,
  parameter int MAX_DELAY       = 4800
) (
  input  logic                       audio_clk,
  input  logic                       rst_in,
  input  logic                       start_in,
  input  logic                       audio_trigger,
  input  logic signed [SAMPLE_W-1:0] audio_in,
  output logic [ADDR_W-1:0]          write_addr,
  output logic signed [SAMPLE_W-1:0] write_data,
  output logic                       write_en,
  output logic [ADDR_W-1:0]          delay_length,
  output logic                       impulse_in_memory_complete,
  output logic                       busy_out,
  output logic                       timeout_out
`ifdef IMPULSE_PEAK_TRACK_EN
  ,
  output logic [MAG_W-1:0]           peak_out
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMPULSE_LENGTH - 1);
  localparam logic [ADDR_W-1:0] MAX_CNT   = ADDR_W'(MAX_DELAY);
  localparam logic [MAG_W-1:0]  ONSET_THR = MAG_W'(ONSET_THRESHOLD);

  rec_state_t                 state_q, state_d;
  logic [ADDR_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]          next_addr_q, next_addr_d;
  logic                       wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic signed [SAMPLE_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]          delay_q, delay_d;
  logic                       complete_q, complete_d;
  logic                       timeout_q, timeout_d;
  logic                       onset;

  onset_detector u_onset (
    .sample_i    (audio_in),
    .threshold_i (ONSET_THR),
    .hit_o       (onset)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    next_addr_d = next_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    delay_d     = delay_q;
    complete_d  = complete_q;
    timeout_d   = timeout_q;

    // Completion trails the final write pulse by one cycle.
    if (wr_en_q && (wr_addr_q == LAST_ADDR)) complete_d = 1'b1;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          complete_d  = 1'b0;
          timeout_d   = 1'b0;
          cnt_d       = '0;
          next_addr_d = '0;
          wr_addr_d   = '0;
          delay_d     = '0;
          state_d     = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (cnt_q >= MAX_CNT) begin
          timeout_d = 1'b1;
          delay_d   = '0;
          state_d   = ST_IDLE;
        end else if (audio_trigger) begin
          if (onset) begin
            delay_d     = cnt_q + ADDR_W'(1);
            wr_en_d     = 1'b1;
            wr_addr_d   = '0;
            wr_data_d   = audio_in;
            next_addr_d = ADDR_W'(1);
            state_d     = (LAST_ADDR == '0) ? ST_DONE : ST_RECORDING;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      ST_RECORDING: begin
        if (audio_trigger) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = next_addr_q;
          wr_data_d   = audio_in;
          next_addr_d = next_addr_q + ADDR_W'(1);
          if (next_addr_q == LAST_ADDR) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      next_addr_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      delay_q     <= '0;
      complete_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      next_addr_q <= next_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      delay_q     <= delay_d;
      complete_q  <= complete_d;
      timeout_q   <= timeout_d;
    end
  end

  assign write_en                   = wr_en_q;
  assign write_addr                 = wr_addr_q;
  assign write_data                 = wr_data_q;
  assign delay_length               = delay_q;
  assign impulse_in_memory_complete = complete_q;
  assign timeout_out                = timeout_q;
  assign busy_out                   = (state_q == ST_ARMED) || (state_q == ST_RECORDING);

`ifdef IMPULSE_PEAK_TRACK_EN
  logic [MAG_W-1:0] peak_q;
  logic             new_peak;
  logic             start_accept;

  assign start_accept = start_in && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Threshold of peak+1 turns the detector into a strict "larger than peak" test.
  onset_detector u_peak (
    .sample_i    (wr_data_q),
    .threshold_i (peak_q + MAG_W'(1)),
    .hit_o       (new_peak)
  );

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      peak_q <= '0;
    end else if (start_accept) begin
      peak_q <= '0;
    end else if (wr_en_q && new_peak) begin
      peak_q <= sample_magnitude(wr_data_q);
    end
  end

  assign peak_out = peak_q;
`endif

endmodule

// File: tb/tb_impulse_recorder.sv
// Self-checking bench for impulse_recorder (IMPULSE_LENGTH=8, MAX_DELAY=5):
// directed scenarios plus randomized captures against a plain reference model.
module tb_impulse_recorder;

  localparam int LEN  = 8;
  localparam int THR  = 2000;
  localparam int MAXD = 5;

  logic               audio_clk = 1'b0;
  logic               rst_in = 1'b1;
  logic               start_in = 1'b0;
  logic               audio_trigger = 1'b0;
  logic signed [15:0] audio_in = '0;
  logic [15:0]        write_addr;
  logic signed [15:0] write_data;
  logic               write_en;
  logic [15:0]        delay_length;
  logic               impulse_in_memory_complete;
  logic               busy_out;
  logic               timeout_out;
`ifdef IMPULSE_PEAK_TRACK_EN
  logic [16:0]        peak_out;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int wr_count  = 0;

  impulse_recorder #(
    .IMPULSE_LENGTH  (LEN),
    .ONSET_THRESHOLD (THR),
    .MAX_DELAY       (MAXD)
  ) dut (
    .audio_clk                  (audio_clk),
    .rst_in                     (rst_in),
    .start_in                   (start_in),
    .audio_trigger              (audio_trigger),
    .audio_in                   (audio_in),
    .write_addr                 (write_addr),
    .write_data                 (write_data),
    .write_en                   (write_en),
    .delay_length               (delay_length),
    .impulse_in_memory_complete (impulse_in_memory_complete),
    .busy_out                   (busy_out),
    .timeout_out                (timeout_out)
`ifdef IMPULSE_PEAK_TRACK_EN
    ,
    .peak_out                   (peak_out)
`endif
  );

  always #5 audio_clk = ~audio_clk;

  always @(negedge audio_clk) if (write_en === 1'b1) wr_count++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int mag(input logic signed [15:0] s);
    int v;
    v = int'(s);
    return (v < 0) ? -v : v;
  endfunction

  task automatic tick();
    @(posedge audio_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle(2);
    rst_in = 1'b0;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] s);
    audio_trigger = 1'b1;
    audio_in = s;
    tick();
    audio_trigger = 1'b0;
    audio_in = 16'($urandom);
  endtask

  function automatic logic signed [15:0] rand_sub();
    return 16'(int'($urandom_range(0, 2 * (THR - 1))) - (THR - 1));
  endfunction

  function automatic logic signed [15:0] rand_onset();
    int v;
    v = int'($urandom_range(THR, 32768));
    if ($urandom_range(0, 1) == 1) v = -v;
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({write_en, write_addr, write_data, delay_length, impulse_in_memory_complete, busy_out, timeout_out} !== '0)
      $display("FAIL reset_outputs got en=%b addr=%0d data=%0d dly=%0d cmp=%b busy=%b to=%b want all 0",
               write_en, write_addr, write_data, delay_length, impulse_in_memory_complete, busy_out, timeout_out);
    else pass_cnt++;
    send(16'sd5000);
    tick();
    total_cnt++;
    if ({write_en, busy_out, wr_count} !== {1'b0, 1'b0, 32'd0})
      $display("FAIL idle_trigger got en=%b busy=%b writes=%0d want 0 0 0", write_en, busy_out, wr_count);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic signed [15:0] seq [3];
    logic signed [15:0] x;
    seq[0] = 16'sd0; seq[1] = 16'sd100; seq[2] = -16'sd50;
    // Onset-sized trigger coinciding with start must be ignored.
    start_in = 1'b1; audio_trigger = 1'b1; audio_in = 16'sd5000;
    tick();
    start_in = 1'b0; audio_trigger = 1'b0;
    total_cnt++;
    if ({busy_out, write_en} !== 2'b10)
      $display("FAIL basic_armed got busy=%b en=%b want busy=1 en=0", busy_out, write_en);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      send(seq[i]);
      total_cnt++;
      if (write_en !== 1'b0) $display("FAIL basic_subthr_%0d got en=%b want 0", i, write_en);
      else pass_cnt++;
    end
    send(16'sd3000);
    total_cnt++;
    if ({write_en, write_addr, write_data} !== {1'b1, 16'd0, 16'sd3000})
      $display("FAIL basic_first_write got en=%b addr=%0d data=%0d want 1 0 3000", write_en, write_addr, write_data);
    else pass_cnt++;
    total_cnt++;
    if (delay_length !== 16'd4) $display("FAIL basic_delay got %0d want 4", delay_length);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (write_en !== 1'b0) $display("FAIL basic_single_pulse got en=%b want 0", write_en);
    else pass_cnt++;
    for (int i = 1; i < LEN; i++) begin
      x = 16'($urandom);
      send(x);
      total_cnt++;
      if ({write_en, write_addr, write_data} !== {1'b1, 16'(i), x})
        $display("FAIL basic_write_%0d got en=%b addr=%0d data=%0d want 1 %0d %0d", i, write_en, write_addr, write_data, i, x);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({impulse_in_memory_complete, busy_out, delay_length} !== {1'b1, 1'b0, 16'd4})
      $display("FAIL basic_done got cmp=%b busy=%b dly=%0d want 1 0 4", impulse_in_memory_complete, busy_out, delay_length);
    else pass_cnt++;
  endtask

  task automatic test_full();
    int w0;
    pulse_start();
    send(-16'sd2500);
    total_cnt++;
    if ({write_en, write_addr, delay_length} !== {1'b1, 16'd0, 16'd1})
      $display("FAIL full_onset got en=%b addr=%0d dly=%0d want 1 0 1", write_en, write_addr, delay_length);
    else pass_cnt++;
    for (int i = 1; i < LEN; i++) begin
      idle(int'($urandom_range(0, 2)));
      send(16'(i * 7));
      total_cnt++;
      if ({write_en, write_addr} !== {1'b1, 16'(i)})
        $display("FAIL full_addr_%0d got en=%b addr=%0d want 1 %0d", i, write_en, write_addr, i);
      else pass_cnt++;
    end
    total_cnt++;
    if (impulse_in_memory_complete !== 1'b0) $display("FAIL full_complete_early got %b want 0", impulse_in_memory_complete);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (impulse_in_memory_complete !== 1'b1) $display("FAIL full_complete got %b want 1", impulse_in_memory_complete);
    else pass_cnt++;
    w0 = wr_count;
    for (int i = 0; i < 3; i++) begin
      send(16'sd9000);
      idle(1);
    end
    total_cnt++;
    if ({wr_count, impulse_in_memory_complete} !== {w0, 1'b1})
      $display("FAIL full_extra_triggers got writes=%0d cmp=%b want %0d 1", wr_count, impulse_in_memory_complete, w0);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int w0;
    pulse_start();
    total_cnt++;
    if ({impulse_in_memory_complete, busy_out} !== 2'b01)
      $display("FAIL timeout_start_clears got cmp=%b busy=%b want 0 1", impulse_in_memory_complete, busy_out);
    else pass_cnt++;
    w0 = wr_count;
    for (int i = 0; i < MAXD; i++) send(16'sd0);
    idle(2);
    total_cnt++;
    if ({timeout_out, busy_out, impulse_in_memory_complete, delay_length} !== {1'b1, 1'b0, 1'b0, 16'd0})
      $display("FAIL timeout_state got to=%b busy=%b cmp=%b dly=%0d want 1 0 0 0",
               timeout_out, busy_out, impulse_in_memory_complete, delay_length);
    else pass_cnt++;
    total_cnt++;
    if (wr_count !== w0) $display("FAIL timeout_no_write got writes=%0d want %0d", wr_count, w0);
    else pass_cnt++;
    pulse_start();
    total_cnt++;
    if (timeout_out !== 1'b0) $display("FAIL timeout_cleared got %b want 0", timeout_out);
    else pass_cnt++;
  endtask

  task automatic test_negative_full_scale();
    do_reset();
    pulse_start();
    send(-16'sd32768);
    total_cnt++;
    if ({write_en, write_addr, write_data, delay_length} !== {1'b1, 16'd0, 16'h8000, 16'd1})
      $display("FAIL neg_onset got en=%b addr=%0d data=%0d dly=%0d want 1 0 -32768 1", write_en, write_addr, write_data, delay_length);
    else pass_cnt++;
    for (int i = 1; i < LEN; i++) send(rand_sub());
    tick();
    total_cnt++;
    if (impulse_in_memory_complete !== 1'b1) $display("FAIL neg_complete got %b want 1", impulse_in_memory_complete);
    else pass_cnt++;
`ifdef IMPULSE_PEAK_TRACK_EN
    total_cnt++;
    if (peak_out !== 17'd32768) $display("FAIL neg_peak got %0d want 32768", peak_out);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_capture();
    logic signed [15:0] x;
    do_reset();
    pulse_start();
    send(16'sd5000);
    send(16'sd1);
    send(16'sd2);
    rst_in = 1'b1;
    tick();
    total_cnt++;
    if ({write_en, write_addr, write_data, delay_length, impulse_in_memory_complete, busy_out, timeout_out} !== '0)
      $display("FAIL midreset_outputs got en=%b addr=%0d data=%0d dly=%0d cmp=%b busy=%b to=%b want all 0",
               write_en, write_addr, write_data, delay_length, impulse_in_memory_complete, busy_out, timeout_out);
    else pass_cnt++;
`ifdef IMPULSE_PEAK_TRACK_EN
    total_cnt++;
    if (peak_out !== 17'd0) $display("FAIL midreset_peak got %0d want 0", peak_out);
    else pass_cnt++;
`endif
    rst_in = 1'b0;
    send(16'sd7000);
    total_cnt++;
    if ({write_en, busy_out} !== 2'b00) $display("FAIL midreset_not_resumed got en=%b busy=%b want 0 0", write_en, busy_out);
    else pass_cnt++;
    pulse_start();
    send(16'sd2100);
    total_cnt++;
    if ({write_en, write_addr, write_data, delay_length} !== {1'b1, 16'd0, 16'sd2100, 16'd1})
      $display("FAIL midreset_restart got en=%b addr=%0d data=%0d dly=%0d want 1 0 2100 1", write_en, write_addr, write_data, delay_length);
    else pass_cnt++;
    for (int i = 1; i < LEN; i++) begin
      x = 16'($urandom);
      send(x);
      total_cnt++;
      if ({write_en, write_addr, write_data} !== {1'b1, 16'(i), x})
        $display("FAIL midreset_write_%0d got en=%b addr=%0d data=%0d want 1 %0d %0d", i, write_en, write_addr, write_data, i, x);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    pulse_start();
    send(16'sd3000);
    pulse_start();
    total_cnt++;
    if ({busy_out, delay_length} !== {1'b1, 16'd1})
      $display("FAIL startign_busy got busy=%b dly=%0d want 1 1", busy_out, delay_length);
    else pass_cnt++;
    for (int i = 1; i < LEN; i++) begin
      send(16'(-i));
      total_cnt++;
      if ({write_en, write_addr} !== {1'b1, 16'(i)})
        $display("FAIL startign_addr_%0d got en=%b addr=%0d want 1 %0d", i, write_en, write_addr, i);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (impulse_in_memory_complete !== 1'b1) $display("FAIL startign_complete got %b want 1", impulse_in_memory_complete);
    else pass_cnt++;
    pulse_start();
    total_cnt++;
    if ({impulse_in_memory_complete, busy_out, delay_length} !== {1'b0, 1'b1, 16'd0})
      $display("FAIL startign_restart got cmp=%b busy=%b dly=%0d want 0 1 0", impulse_in_memory_complete, busy_out, delay_length);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int k;
    int peak;
    logic signed [15:0] x;
    do_reset();
    for (int it = 0; it < 25; it++) begin
      k = int'($urandom_range(0, MAXD));
      peak = 0;
      pulse_start();
      for (int j = 0; j < k; j++) begin
        idle(int'($urandom_range(0, 2)));
        send(rand_sub());
      end
      if (k >= MAXD) begin
        idle(2);
        total_cnt++;
        if ({timeout_out, busy_out, delay_length} !== {1'b1, 1'b0, 16'd0})
          $display("FAIL rand%0d_timeout got to=%b busy=%b dly=%0d want 1 0 0", it, timeout_out, busy_out, delay_length);
        else pass_cnt++;
      end else begin
        x = rand_onset();
        send(x);
        peak = mag(x);
        total_cnt++;
        if ({write_en, write_addr, write_data, delay_length} !== {1'b1, 16'd0, x, 16'(k + 1)})
          $display("FAIL rand%0d_onset got en=%b addr=%0d data=%0d dly=%0d want 1 0 %0d %0d",
                   it, write_en, write_addr, write_data, delay_length, x, k + 1);
        else pass_cnt++;
        for (int i = 1; i < LEN; i++) begin
          idle(int'($urandom_range(0, 2)));
          x = 16'($urandom);
          send(x);
          if (mag(x) > peak) peak = mag(x);
          total_cnt++;
          if ({write_en, write_addr, write_data} !== {1'b1, 16'(i), x})
            $display("FAIL rand%0d_write_%0d got en=%b addr=%0d data=%0d want 1 %0d %0d",
                     it, i, write_en, write_addr, write_data, i, x);
          else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({impulse_in_memory_complete, timeout_out, busy_out, delay_length} !== {1'b1, 1'b0, 1'b0, 16'(k + 1)})
          $display("FAIL rand%0d_done got cmp=%b to=%b busy=%b dly=%0d want 1 0 0 %0d",
                   it, impulse_in_memory_complete, timeout_out, busy_out, delay_length, k + 1);
        else pass_cnt++;
`ifdef IMPULSE_PEAK_TRACK_EN
        total_cnt++;
        if (peak_out !== 17'(peak)) $display("FAIL rand%0d_peak got %0d want %0d", it, peak_out, peak);
        else pass_cnt++;
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_timeout();
    test_negative_full_scale();
    test_reset_mid_capture();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/impulse_recorder.md
IMPULSE_RECORDER -- requirements
Module: impulse_recorder

Interface
REQ-001 Parameter IMPULSE_LENGTH, default 48000: number of samples captured into impulse memory, 1..65535.
REQ-002 Parameter ONSET_THRESHOLD, default 2000: magnitude at or above which a sample is the impulse onset.
REQ-003 Parameter MAX_DELAY, default 4800: number of sub-threshold samples after arming before timeout.
REQ-004 audio_clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 start_in  input  1  single-cycle pulse that arms a capture.
REQ-007 audio_trigger  input  1  single-cycle strobe; audio_in is valid this cycle.
REQ-008 audio_in  input  16 signed  microphone sample.
REQ-009 write_addr  output  16  impulse memory write address.
REQ-010 write_data  output  16 signed  impulse memory write data.
REQ-011 write_en  output  1  single-cycle memory write strobe.
REQ-012 delay_length  output  16  measured acoustic delay in samples, 1-based index of the onset sample.
REQ-013 impulse_in_memory_complete  output  1  level; all IMPULSE_LENGTH samples written.
REQ-014 busy_out  output  1  high in ARMED and RECORDING.
REQ-015 timeout_out  output  1  level; last capture found no onset.

Function
REQ-016 FSM states: IDLE, ARMED, RECORDING, DONE.
REQ-017 IDLE or DONE, start_in=1: clear complete, timeout, delay counter and address; go to ARMED next cycle; an audio_trigger in that same cycle is ignored.
REQ-018 start_in in ARMED or RECORDING: ignored.
REQ-019 Magnitude: 17-bit |audio_in|; -32768 yields 32768, never wraps.
REQ-020 ARMED, audio_trigger, magnitude < ONSET_THRESHOLD: delay counter increments; no write.
REQ-021 ARMED, audio_trigger, magnitude >= ONSET_THRESHOLD: delay_length <= counter+1; sample written at address 0; go to RECORDING.
REQ-022 ARMED, counter reaches MAX_DELAY: timeout_out <= 1, delay_length <= 0, go to IDLE; complete stays 0.
REQ-023 RECORDING: each audio_trigger writes the sample at the next address (1, 2, ...).
REQ-024 Write latency: write_en, write_addr, write_data registered, valid exactly 1 cycle after the accepted audio_trigger; write_en high for one cycle per sample.
REQ-025 Write with address IMPULSE_LENGTH-1 ends capture: go to DONE; impulse_in_memory_complete high the cycle after that write_en pulse, held until next start_in or reset.
REQ-026 Address never exceeds IMPULSE_LENGTH-1; no wrap-around writes.
REQ-027 audio_trigger outside ARMED/RECORDING: no effect.
REQ-028 delay_length holds its value from onset until next start_in or reset.

Reset
REQ-029 rst_in, any state including mid-capture: FSM to IDLE, write_en 0, write_addr 0, write_data 0, delay_length 0, complete 0, busy_out 0, timeout_out 0, peak_out 0 (if built).
REQ-030 A capture interrupted by reset is not resumed; memory contents are left as written.

Configuration
REQ-031 Macro IMPULSE_PEAK_TRACK_EN defined: output peak_out (17 bits) holds max magnitude of all samples written in current capture, cleared on start_in, updated 1 cycle after each write.
REQ-032 Macro undefined: no peak_out port and no peak logic.

Structure
REQ-033 Shared package aurras_pkg holds the recorder state enum, sample width (16) and magnitude width (17).
REQ-034 Sub-module onset_detector: combinational 17-bit magnitude and threshold compare, reused for peak tracking.

Verification
REQ-035 Reset, start_in, triggers with samples 0,100,-50,3000 -> delay_length=4; first write addr 0 data 3000, 1 cycle after 4th trigger.
REQ-036 IMPULSE_LENGTH=8, onset at first sample, 8 triggers -> addrs 0..7 written once each; complete high the cycle after addr 7 write; extra triggers cause no write.
REQ-037 MAX_DELAY=5, five samples of 0 -> timeout_out=1, state IDLE, complete=0, no write_en.
REQ-038 Onset sample -32768 -> accepted as onset, write_data=-32768; with IMPULSE_PEAK_TRACK_EN peak_out=32768.
REQ-039 rst_in asserted after 3 of 8 writes -> all outputs at reset values next cycle; new start_in restarts at addr 0.
REQ-040 start_in pulsed in RECORDING -> ignored, capture completes normally; start_in in DONE -> complete drops next cycle.
